// File: rtl/vip_bit_region_stats.sv
// Per-frame set-pixel count and bounding box for the 1-bit morphology stream.
// Optional ROI gating is compiled in with `define VIP_STATS_ROI_EN.
module vip_bit_region_stats #(
  parameter logic [10:0] IMG_HDISP = 11'd1024,
  parameter logic [10:0] IMG_VDISP = 11'd768,
  parameter logic [10:0] ROI_X0    = 11'd0,
  parameter logic [10:0] ROI_X1    = 11'd1023,
  parameter logic [10:0] ROI_Y0    = 11'd0,
  parameter logic [10:0] ROI_Y1    = 11'd767
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        per_img_Bit,
  output logic        stats_valid,
  output logic        obj_found,
  output logic [20:0] pix_cnt,
  output logic [10:0] x_min,
  output logic [10:0] x_max,
  output logic [10:0] y_min,
  output logic [10:0] y_max,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t      state, state_next;
  logic        vsync_d, href_d;
  logic        rise, fall, href_fall;
  logic        clear, frame_end, sample, in_area, in_roi, hit;
  logic [10:0] x, y;
  logic [20:0] acc_cnt;
  logic [10:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;

  if (ROI_X0 > ROI_X1 || ROI_Y0 > ROI_Y1) begin : g_bad_roi
    $error("vip_bit_region_stats: ROI bounds are inverted");
  end

  assign rise      = per_frame_vsync & ~vsync_d;
  assign fall      = ~per_frame_vsync & vsync_d;
  assign href_fall = ~per_frame_href & href_d;
  assign frame_end = (state == ACCUM) && fall;

  assign sample  = (state == ACCUM) && per_frame_vsync && per_frame_href && per_frame_clken;
  assign in_area = (x < IMG_HDISP) && (y < IMG_VDISP);
`ifdef VIP_STATS_ROI_EN
  assign in_roi  = (x >= ROI_X0) && (x <= ROI_X1) && (y >= ROI_Y0) && (y <= ROI_Y1);
`else
  assign in_roi  = 1'b1;
`endif
  assign hit = sample && per_img_Bit && in_area && in_roi;

  // vsync_d resets high so a reset released mid-frame cannot fake a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b1;
      href_d  <= 1'b0;
      state   <= IDLE;
    end else begin
      vsync_d <= per_frame_vsync;
      href_d  <= per_frame_href;
      state   <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = ACCUM;
          clear      = 1'b1;
        end
      end
      ACCUM: begin
        if (fall) state_next = DONE;
      end
      DONE: begin
        if (rise) begin
          state_next = ACCUM;
          clear      = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      acc_cnt  <= '0;
      acc_xmin <= '1;
      acc_ymin <= '1;
      acc_xmax <= '0;
      acc_ymax <= '0;
    end else if (clear) begin
      x        <= '0;
      y        <= '0;
      acc_cnt  <= '0;
      acc_xmin <= '1;
      acc_ymin <= '1;
      acc_xmax <= '0;
      acc_ymax <= '0;
    end else if (state == ACCUM) begin
      if (href_fall) begin
        x <= '0;
        if (y != 11'h7FF) y <= y + 11'd1;
      end else if (sample && x != 11'h7FF) begin
        x <= x + 11'd1;
      end
      if (hit) begin
        if (acc_cnt != '1) acc_cnt <= acc_cnt + 21'd1;
        if (x < acc_xmin) acc_xmin <= x;
        if (x > acc_xmax) acc_xmax <= x;
        if (y < acc_ymin) acc_ymin <= y;
        if (y > acc_ymax) acc_ymax <= y;
      end
    end
  end

  // Empty frames report an all-zero box rather than the cleared sentinels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stats_valid <= 1'b0;
      obj_found   <= 1'b0;
      pix_cnt     <= '0;
      x_min       <= '0;
      x_max       <= '0;
      y_min       <= '0;
      y_max       <= '0;
      frame_cnt   <= '0;
    end else begin
      stats_valid <= frame_end;
      if (frame_end) begin
        obj_found <= (acc_cnt != '0);
        pix_cnt   <= acc_cnt;
        x_min     <= (acc_cnt != '0) ? acc_xmin : 11'd0;
        x_max     <= (acc_cnt != '0) ? acc_xmax : 11'd0;
        y_min     <= (acc_cnt != '0) ? acc_ymin : 11'd0;
        y_max     <= (acc_cnt != '0) ? acc_ymax : 11'd0;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vip_bit_region_stats.sv
// Directed and randomized frames for vip_bit_region_stats, checked against a
// pixel-array model of the frame statistics.
module tb_vip_bit_region_stats;
  localparam int H = 16;
  localparam int V = 8;
`ifdef VIP_STATS_ROI_EN
  localparam int RX0 = 4, RX1 = 7, RY0 = 2, RY1 = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0, href = 1'b0, clken = 1'b0, bit_in = 1'b0;
  logic        stats_valid, obj_found;
  logic [20:0] pix_cnt;
  logic [10:0] x_min, x_max, y_min, y_max;
  logic [7:0]  frame_cnt;

  int tests = 0;
  int fails = 0;
  int exp_frames = 0;
  bit pat [0:31][0:31];

  vip_bit_region_stats #(
    .IMG_HDISP(11'd16), .IMG_VDISP(11'd8)
`ifdef VIP_STATS_ROI_EN
    , .ROI_X0(11'd4), .ROI_X1(11'd7), .ROI_Y0(11'd2), .ROI_Y1(11'd3)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_Bit(bit_in),
    .stats_valid(stats_valid), .obj_found(obj_found), .pix_cnt(pix_cnt),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void fill(input int mode);
    for (int yy = 0; yy < 32; yy++)
      for (int xx = 0; xx < 32; xx++)
        case (mode)
          0:       pat[yy][xx] = 1'b0;
          1:       pat[yy][xx] = 1'b1;
          2:       pat[yy][xx] = ($urandom_range(0, 5) == 0);
          3:       pat[yy][xx] = (xx == 3 && yy == 2);
          default: pat[yy][xx] = (xx == 18) || (yy == 8);
        endcase
  endfunction

  // One line of np strobes with random clken gaps, then one blank cycle.
  task automatic send_line(input int yy, input int np);
    int n = 0;
    href = 1'b1;
    while (n < np) begin
      clken = ($urandom_range(0, 3) != 0);
      if (clken) begin
        bit_in = pat[yy][n];
        n++;
      end else begin
        bit_in = 1'($urandom_range(0, 1));
      end
      tick();
    end
    href = 1'b0; clken = 1'b0; bit_in = 1'b0;
    tick();
  endtask

  task automatic check_frame(input string tag, input int nl, input int np);
    int cnt = 0, xmn = 2047, xmx = 0, ymn = 2047, ymx = 0;
    bit ok;
    for (int yy = 0; yy < nl; yy++)
      for (int xx = 0; xx < np; xx++) begin
        ok = pat[yy][xx] && xx < H && yy < V;
`ifdef VIP_STATS_ROI_EN
        ok = ok && xx >= RX0 && xx <= RX1 && yy >= RY0 && yy <= RY1;
`endif
        if (ok) begin
          cnt++;
          if (xx < xmn) xmn = xx;
          if (xx > xmx) xmx = xx;
          if (yy < ymn) ymn = yy;
          if (yy > ymx) ymx = yy;
        end
      end
    if (cnt == 0) begin
      xmn = 0; xmx = 0; ymn = 0; ymx = 0;
    end
    exp_frames = (exp_frames + 1) % 256;
    chk({tag, ".valid"}, 32'(stats_valid), 32'd1);
    chk({tag, ".pix_cnt"}, 32'(pix_cnt), 32'(cnt));
    chk({tag, ".obj_found"}, 32'(obj_found), 32'(cnt != 0));
    chk({tag, ".x_min"}, 32'(x_min), 32'(xmn));
    chk({tag, ".x_max"}, 32'(x_max), 32'(xmx));
    chk({tag, ".y_min"}, 32'(y_min), 32'(ymn));
    chk({tag, ".y_max"}, 32'(y_max), 32'(ymx));
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
  endtask

  // Frame results are expected exactly one cycle after vsync drops.
  task automatic send_frame(input string tag, input int nl, input int np, input bit b2b);
    vsync = 1'b1;
    tick();
    tick();
    for (int yy = 0; yy < nl; yy++) send_line(yy, np);
    vsync = 1'b0;
    tick();
    check_frame(tag, nl, np);
    if (!b2b) begin
      tick();
      chk({tag, ".pulse_end"}, 32'(stats_valid), 32'd0);
      tick();
      tick();
    end
  endtask

  initial begin
    tick();
    tick();
    chk("reset.valid", 32'(stats_valid), 32'd0);
    chk("reset.pix_cnt", 32'(pix_cnt), 32'd0);
    chk("reset.box", {x_min[7:0], x_max[7:0], y_min[7:0], y_max[7:0]}, 32'd0);
    chk("reset.frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    fill(3); send_frame("single", V, H, 1'b0);
    fill(0); send_frame("empty", V, H, 1'b0);
    fill(1); send_frame("ones", V, H, 1'b0);

    for (int i = 0; i < 6; i++) begin
      fill(2);
      send_frame("rand", $urandom_range(1, 10), $urandom_range(1, 20), (i % 2) == 0);
    end

    // Reset pulsed mid-frame: the partial frame must produce no result.
    fill(1);
    vsync = 1'b1;
    tick();
    tick();
    for (int yy = 0; yy < 3; yy++) send_line(yy, H);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_frames = 0;
    for (int yy = 3; yy < V; yy++) send_line(yy, H);
    vsync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midreset.no_valid", 32'(stats_valid), 32'd0);
    end
    chk("midreset.frame_cnt", 32'(frame_cnt), 32'd0);
    send_frame("after_reset", V, H, 1'b0);

    fill(4); send_frame("outside", V + 1, 20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
